// File: rtl/ucode_pkg.sv
// ucode_pkg: microword layout, branch-condition codes and sequencer states
package ucode_pkg;
    localparam int AW    = 5;
    localparam int DEPTH = 18;
    localparam int CW    = 15;
    localparam int NFLAG = 3;
    localparam int UW    = 23;
    localparam int COND_MSB = 22;
    localparam int COND_LSB = 20;
    localparam int NXT_MSB  = 19;
    localparam int NXT_LSB  = 15;
    localparam int CTRL_MSB = 14;
    localparam int CTRL_LSB = 0;
    typedef enum logic [2:0] {
        C_SEQ = 3'b000,
        C_F0  = 3'b001,
        C_F1  = 3'b010,
        C_F2  = 3'b011,
        C_JMP = 3'b100
    } cond_e;
    // cond kept as plain bits so the reserved codes 101..111 remain representable
    typedef struct packed {
        logic [2:0]    cond;
        logic [AW-1:0] nxt;
        logic [CW-1:0] ctrl;
    } uword_t;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
endpackage

// File: rtl/useq_branch_sel.sv
// useq_branch_sel: next micro-address select with halt and illegal-address detect
// Ports:
//   upc        current micro-PC
//   cond, nxt  branch fields of the current microword
//   cond_flags datapath flags (0 mult LSB, 1 counter-zero, 2 sign)
//   next_addr  selected next address (low AW bits)
//   halt       unconditional self-jump
//   illegal    selected next address is beyond the populated store
module useq_branch_sel
    import ucode_pkg::*;
(
    input  logic [AW-1:0]    upc,
    input  logic [2:0]       cond,
    input  logic [AW-1:0]    nxt,
    input  logic [NFLAG-1:0] cond_flags,
    output logic [AW-1:0]    next_addr,
    output logic             halt,
    output logic             illegal
);
    logic [AW:0] seq_addr;
    logic [AW:0] full_addr;
    logic        take;
    // one extra bit so 31+1 lands on 32 and is flagged rather than wrapping to 0
    assign seq_addr  = {1'b0, upc} + (AW+1)'(1);
    assign take      = (cond == C_JMP)
                    || (cond == C_F0 && cond_flags[0])
                    || (cond == C_F1 && cond_flags[1])
                    || (cond == C_F2 && cond_flags[2]);
    assign full_addr = take ? {1'b0, nxt} : seq_addr;
    assign next_addr = full_addr[AW-1:0];
    assign illegal   = full_addr >= (AW+1)'(DEPTH);
    assign halt      = (cond == C_JMP) && (nxt == upc);
endmodule

// File: rtl/useq_ctrl.sv
// useq_ctrl: microprogram sequencer for the Robertson multiplier control store
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   start        host request, honoured in IDLE or DONE
//   stall        freezes uPC and state for the cycle while in RUN
//   cond_flags   datapath status flags
//   rom_addr     control-store address (= uPC)
//   rom_data     microword at rom_addr
//   ctrl         control field to datapath, zero unless issuing
//   busy, done   RUN / DONE indicators
//   err          sticky illegal-address error, cleared by start or reset
module useq_ctrl
    import ucode_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stall,
    input  logic [NFLAG-1:0] cond_flags,
    output logic [AW-1:0]    rom_addr,
    input  logic [UW-1:0]    rom_data,
    output logic [CW-1:0]    ctrl,
    output logic             busy,
    output logic             done,
    output logic             err
);
    state_e        state;
    logic [AW-1:0] upc;
    logic [AW-1:0] next_addr;
    logic          halt;
    logic          illegal;
    logic          issue;
    uword_t        uw;
    assign uw = uword_t'(rom_data);
    useq_branch_sel u_sel (
        .upc        (upc),
        .cond       (uw.cond),
        .nxt        (uw.nxt),
        .cond_flags (cond_flags),
        .next_addr  (next_addr),
        .halt       (halt),
        .illegal    (illegal)
    );
    // reset gates ctrl in the same cycle, not just after the edge
    assign issue    = rst_n && state == RUN && !stall;
    assign ctrl     = issue ? uw.ctrl : '0;
    assign rom_addr = upc;
    assign busy     = state == RUN;
    assign done     = state == DONE;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            upc   <= '0;
            err   <= 1'b0;
        end else if (state == RUN) begin
            if (!stall) begin
                if (halt) begin
                    state <= DONE;
                end else if (illegal) begin
                    state <= DONE;
                    err   <= 1'b1;
                end else begin
                    upc <= next_addr;
                end
            end
        end else if (start) begin
            state <= RUN;
            upc   <= '0;
            err   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_useq_ctrl.sv
// tb_useq_ctrl: directed self-checking bench for useq_ctrl with a stock microcode ROM
module tb_useq_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        stall;
    logic [2:0]  cond_flags;
    logic [4:0]  rom_addr;
    logic [22:0] rom_data;
    logic [14:0] ctrl;
    logic        busy;
    logic        done;
    logic        err;
    logic [22:0] rom [0:31];
    int          path[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    useq_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stall      (stall),
        .cond_flags (cond_flags),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .ctrl       (ctrl),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;
    assign rom_data = rom[rom_addr];

    function automatic logic [22:0] mw(input logic [2:0] c, input logic [4:0] n, input int k);
        return {c, n, 15'((k + 1) * 1057)};
    endfunction

    function automatic logic [14:0] cw(input int k);
        return 15'((k + 1) * 1057);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic walk();
        foreach (path[i]) begin
            tick();
            check("walk_addr", 32'(rom_addr), 32'(path[i]));
            check("walk_ctrl", 32'(ctrl), 32'(cw(path[i])));
            check("walk_busy", 32'(busy), 32'd1);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 32; k++) rom[k] = '0;
        for (int k = 0; k < 18; k++) rom[k] = mw(3'b000, 5'd0, k);
        rom[3]  = mw(3'b001, 5'd12, 3);
        rom[7]  = mw(3'b010, 5'd17, 7);
        rom[8]  = mw(3'b100, 5'd10, 8);
        rom[9]  = mw(3'b100, 5'd0, 9);
        rom[10] = mw(3'b011, 5'd14, 10);
        rom[11] = mw(3'b100, 5'd3, 11);
        rom[13] = mw(3'b100, 5'd4, 13);
        rom[17] = mw(3'b100, 5'd17, 17);
        rst_n = 1'b0; start = 1'b0; stall = 1'b0; cond_flags = 3'b000;
        tick(); tick();
        check("rst_addr", 32'(rom_addr), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_ctrl", 32'(ctrl), 0);
        rst_n = 1'b1;
        stall = 1'b1;
        tick();
        stall = 1'b0;
        check("idle_addr", 32'(rom_addr), 0);
        check("idle_ctrl", 32'(ctrl), 0);
        check("idle_busy", 32'(busy), 0);
        pulse_start();
        check("start_addr", 32'(rom_addr), 0);
        check("start_busy", 32'(busy), 1);
        check("start_ctrl", 32'(ctrl), 32'(cw(0)));
        path = '{1, 2, 3, 4, 5, 6, 7, 8, 10, 11, 3};
        walk();
        cond_flags = 3'b001;
        tick();
        cond_flags = 3'b000;
        check("f0_taken", 32'(rom_addr), 12);
        path = '{13, 4, 5};
        walk();
        stall = 1'b1;
        #1;
        check("stall_ctrl0", 32'(ctrl), 0);
        repeat (3) begin
            tick();
            check("stall_addr", 32'(rom_addr), 5);
            check("stall_ctrl", 32'(ctrl), 0);
            check("stall_busy", 32'(busy), 1);
        end
        stall = 1'b0;
        #1;
        check("unstall_ctrl", 32'(ctrl), 32'(cw(5)));
        path = '{6, 7};
        walk();
        cond_flags = 3'b010;
        start = 1'b1;
        tick();
        start = 1'b0;
        cond_flags = 3'b000;
        check("f1_taken", 32'(rom_addr), 17);
        check("halt_ctrl", 32'(ctrl), 32'(cw(17)));
        check("halt_busy", 32'(busy), 1);
        tick();
        check("done_done", 32'(done), 1);
        check("done_busy", 32'(busy), 0);
        check("done_ctrl", 32'(ctrl), 0);
        check("done_addr", 32'(rom_addr), 17);
        check("done_err", 32'(err), 0);
        stall = 1'b1;
        tick();
        stall = 1'b0;
        check("done_hold", 32'(done), 1);
        pulse_start();
        check("restart_addr", 32'(rom_addr), 0);
        check("restart_busy", 32'(busy), 1);
        check("restart_done", 32'(done), 0);
        path = '{1, 2, 3, 4, 5, 6, 7, 8, 10};
        walk();
        cond_flags = 3'b100;
        tick();
        cond_flags = 3'b000;
        check("f2_taken", 32'(rom_addr), 14);
        path = '{15, 16, 17};
        walk();
        tick();
        check("halt2_done", 32'(done), 1);
        rom[17] = mw(3'b000, 5'd0, 17);
        pulse_start();
        check("ill_start", 32'(rom_addr), 0);
        path = '{1, 2, 3, 4, 5, 6, 7};
        walk();
        cond_flags = 3'b010;
        tick();
        cond_flags = 3'b000;
        check("ill_at17", 32'(rom_addr), 17);
        check("ill_err_pre", 32'(err), 0);
        tick();
        check("ill_done", 32'(done), 1);
        check("ill_err", 32'(err), 1);
        check("ill_busy", 32'(busy), 0);
        check("ill_addr", 32'(rom_addr), 17);
        check("ill_ctrl", 32'(ctrl), 0);
        tick();
        check("ill_sticky", 32'(err), 1);
        pulse_start();
        check("errclr_err", 32'(err), 0);
        check("errclr_busy", 32'(busy), 1);
        check("errclr_addr", 32'(rom_addr), 0);
        path = '{1, 2, 3, 4, 5, 6, 7, 8, 10};
        walk();
        rst_n = 1'b0;
        #1;
        check("rstrun_ctrl_comb", 32'(ctrl), 0);
        tick();
        check("rstrun_addr", 32'(rom_addr), 0);
        check("rstrun_busy", 32'(busy), 0);
        check("rstrun_done", 32'(done), 0);
        check("rstrun_err", 32'(err), 0);
        check("rstrun_ctrl", 32'(ctrl), 0);
        rst_n = 1'b1;
        tick();
        check("post_rst_idle", 32'(busy), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
